mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-port arbiter and access sequencer for the shared memory bus (EPROM + RAM) between the processor (port 0) and a DMA/IO master (port 1).
- Grants one requester at a time using round-robin.
- Drives the memory strobes for a fixed number of wait states, returns read data, and acknowledges with a one-cycle pulse.
- Blocks writes into the EPROM region and flags them.

Parameters:
- ADDR_W, 24, address width.
- DATA_W, 8, data width.
- WAIT_CYCLES, 2, cycles the strobe is held low per access (legal range 1..15).
- ROM_BASE, 24'hFF0000, first EPROM address; addresses >= ROM_BASE are read-only.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_  in  1  synchronous reset, active low.
- req0, req1  in  1 each  access request; held high until that port's ack.
- addr0, addr1  in  ADDR_W each  request address; stable while req is high.
- we0, we1  in  1 each  1 = write, 0 = read.
- wdata0, wdata1  in  DATA_W each  write data.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- err0, err1  out  1 each  one-cycle pulse, coincident with ack, on a blocked EPROM write.
- rdata  out  DATA_W  read data; valid in the ack cycle and held until the next read completes.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rd_  out  1  read strobe, active low.
- mem_we_  out  1  write strobe, active low.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (reset_=0 at an edge):
  - State goes to IDLE.
  - ack0, ack1, err0, err1 = 0.
  - mem_rd_ = mem_we_ = 1.
  - mem_addr = 0, mem_wdata = 0, rdata = 0.
  - last_grant = 1, so port 0 wins the first tie.
- Reset mid-access: strobes return high at that edge, the access is abandoned, and no ack is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - At an edge with req0 or req1 high, select a port:
    - If only one port is requesting, select it.
    - If both are requesting, select the port != last_grant.
  - Latch the selected port's addr/we/wdata into mem_addr/mem_wdata.
  - Set last_grant to the selected port, load wait counter = WAIT_CYCLES, go to ACCESS.
  - Assert the strobe in the same edge:
    - Read: mem_rd_ = 0.
    - Write below ROM_BASE: mem_we_ = 0.
    - Write at or above ROM_BASE: no strobe asserted; blocked flag set.
- ACCESS:
  - Decrement the counter each edge.
  - Strobe stays low for exactly WAIT_CYCLES cycles.
  - On the edge where the counter reaches 0:
    - Deassert the strobe.
    - For reads, capture mem_rdata into rdata.
    - Pulse ack of the granted port, plus err if the blocked flag is set.
    - Go to DONE.
- DONE:
  - ack/err return to 0 at the next edge; go to IDLE.
  - Requests are not sampled in DONE. This guarantees one idle cycle between accesses, so a master can drop req after seeing ack.
- Latency: from the IDLE sampling edge to the ack-high cycle is WAIT_CYCLES+1 edges. Back-to-back accesses on one port take WAIT_CYCLES+2 cycles each.
- Request rules:
  - A req raised while the other port is being served waits; it is never lost.
  - A req dropped before its ack is ignored if still in IDLE. Dropping req in ACCESS is illegal and the access still completes.
- Boundaries:
  - addr = ROM_BASE-1 is writable.
  - addr = ROM_BASE is blocked.
  - All-ones address is a legal read.
- Only one ack is high in any cycle; ack0 and ack1 are never high together.

Test Plan:
1. Reset, then req0 read addr 24'h000010 with mem_rdata = 8'hA5:
   - mem_rd_ is low for 2 cycles.
   - ack0 pulses 3 edges after sampling.
   - rdata = 8'hA5.
   - mem_we_ stays 1.
2. req1 write addr 24'h000020, data 8'h3C:
   - mem_we_ is low for 2 cycles with mem_addr = 24'h000020 and mem_wdata = 8'h3C.
   - ack1 pulses; err1 = 0.
3. req0 and req1 raised on the same edge after reset:
   - Port 0 is served first, then port 1.
   - Both raised again: port 1 is served first.
   - Acks never overlap.
4. req0 write to 24'hFF0000:
   - mem_we_ never goes low.
   - ack0 and err0 pulse together.
   - Write to 24'hFEFFFF: mem_we_ low, err0 = 0.
5. reset_ driven low during ACCESS:
   - Strobes are high after that edge.
   - No ack; state IDLE; outputs at reset values.
6. Run with WAIT_CYCLES = 1 and 5: strobe width and ack latency are exactly WAIT_CYCLES and WAIT_CYCLES+1.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port round-robin arbiter and access sequencer for the
// shared EPROM/RAM bus. Port 0 is the processor, port 1 the DMA/IO master.
// Each access holds the selected strobe low for WAIT_CYCLES cycles, then
// returns read data and pulses the granted port's ack. Writes into the
// EPROM window are not strobed and are reported through err.
module mem_bus_arbiter #(
    parameter int                ADDR_W      = 24,
    parameter int                DATA_W      = 8,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] ROM_BASE    = ADDR_W'(24'hFF0000)
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_,
    output logic              mem_we_,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int NUM_PORTS = 2;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Request side gathered into per-port packed vectors so selection is a
    // simple index by port number.
    logic [NUM_PORTS-1:0]             req;
    logic [NUM_PORTS-1:0]             we;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;

    assign req   = {req1, req0};
    assign we    = {we1, we0};
    assign addr  = {addr1, addr0};
    assign wdata = {wdata1, wdata0};

    state_t               state_q, state_n;
    logic                 last_grant_q, last_grant_n;
    logic                 grant_q, grant_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 is_rd_q, is_rd_n;
    logic                 blocked_q, blocked_n;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_n;
    logic                 mem_rd_q, mem_rd_n;
    logic                 mem_we_q, mem_we_n;
    logic [DATA_W-1:0]    rdata_q, rdata_n;
    logic [NUM_PORTS-1:0] ack_q, ack_n;
    logic [NUM_PORTS-1:0] err_q, err_n;

    // Port selection: a lone requester wins outright; on a tie the port
    // that was not served last wins.
    logic sel;
    logic sel_blocked;

    always_comb begin
        sel = 1'b0;
        if (req == 2'b11) begin
            sel = ~last_grant_q;
        end else begin
            sel = req[1];
        end
        sel_blocked = we[sel] && (addr[sel] >= ROM_BASE);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state and next-output logic; every registered output is computed
    // here so the bus pins come straight from flops.
    always_comb begin
        state_n      = state_q;
        last_grant_n = last_grant_q;
        grant_n      = grant_q;
        cnt_n        = cnt_q;
        is_rd_n      = is_rd_q;
        blocked_n    = blocked_q;
        mem_addr_n   = mem_addr_q;
        mem_wdata_n  = mem_wdata_q;
        mem_rd_n     = mem_rd_q;
        mem_we_n     = mem_we_q;
        rdata_n      = rdata_q;
        ack_n        = ack_q;
        err_n        = err_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_n      = sel;
                    last_grant_n = sel;
                    mem_addr_n   = addr[sel];
                    mem_wdata_n  = wdata[sel];
                    is_rd_n      = ~we[sel];
                    blocked_n    = sel_blocked;
                    cnt_n        = CNT_W'(WAIT_CYCLES);
                    // Strobe goes low on the grant edge; a blocked EPROM
                    // write still runs the full timing but never strobes.
                    mem_rd_n     = we[sel];
                    mem_we_n     = ~(we[sel] && !sel_blocked);
                    state_n      = ACCESS;
                end
            end

            ACCESS: begin
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    mem_rd_n = 1'b1;
                    mem_we_n = 1'b1;
                    if (is_rd_q) begin
                        rdata_n = mem_rdata;
                    end
                    ack_n[grant_q] = 1'b1;
                    err_n[grant_q] = blocked_q;
                    state_n        = DONE;
                end
            end

            DONE: begin
                // Requests are ignored here so every master sees a free
                // cycle after its ack to drop req.
                ack_n   = '0;
                err_n   = '0;
                state_n = IDLE;
            end

            default: begin
                state_n  = IDLE;
                mem_rd_n = 1'b1;
                mem_we_n = 1'b1;
                ack_n    = '0;
                err_n    = '0;
            end
        endcase
    end

    // Datapath and output registers; reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            is_rd_q      <= 1'b0;
            blocked_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b1;
            mem_we_q     <= 1'b1;
            rdata_q      <= '0;
            ack_q        <= '0;
            err_q        <= '0;
        end else begin
            last_grant_q <= last_grant_n;
            grant_q      <= grant_n;
            cnt_q        <= cnt_n;
            is_rd_q      <= is_rd_n;
            blocked_q    <= blocked_n;
            mem_addr_q   <= mem_addr_n;
            mem_wdata_q  <= mem_wdata_n;
            mem_rd_q     <= mem_rd_n;
            mem_we_q     <= mem_we_n;
            rdata_q      <= rdata_n;
            ack_q        <= ack_n;
            err_q        <= err_n;
        end
    end

    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign err0      = err_q[0];
    assign err1      = err_q[1];
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd_   = mem_rd_q;
    assign mem_we_   = mem_we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Three instances share clock/reset:
// index 0 uses WAIT_CYCLES=2, index 1 uses 1, index 2 uses 5.
module tb_mem_bus_arbiter;

    logic        clock;
    logic        reset_;
    logic        req0      [3];
    logic        req1      [3];
    logic [23:0] addr0     [3];
    logic [23:0] addr1     [3];
    logic        we0       [3];
    logic        we1       [3];
    logic [7:0]  wdata0    [3];
    logic [7:0]  wdata1    [3];
    logic        ack0      [3];
    logic        ack1      [3];
    logic        err0      [3];
    logic        err1      [3];
    logic [7:0]  rdata     [3];
    logic [23:0] mem_addr  [3];
    logic [7:0]  mem_wdata [3];
    logic        mem_rd_   [3];
    logic        mem_we_   [3];
    logic [7:0]  mem_rdata [3];

    mem_bus_arbiter #(.WAIT_CYCLES(2)) u_w2 (
        .clock(clock), .reset_(reset_),
        .req0(req0[0]), .req1(req1[0]), .addr0(addr0[0]), .addr1(addr1[0]),
        .we0(we0[0]), .we1(we1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .err0(err0[0]), .err1(err1[0]),
        .rdata(rdata[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rd_(mem_rd_[0]), .mem_we_(mem_we_[0]), .mem_rdata(mem_rdata[0])
    );

    mem_bus_arbiter #(.WAIT_CYCLES(1)) u_w1 (
        .clock(clock), .reset_(reset_),
        .req0(req0[1]), .req1(req1[1]), .addr0(addr0[1]), .addr1(addr1[1]),
        .we0(we0[1]), .we1(we1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .err0(err0[1]), .err1(err1[1]),
        .rdata(rdata[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rd_(mem_rd_[1]), .mem_we_(mem_we_[1]), .mem_rdata(mem_rdata[1])
    );

    mem_bus_arbiter #(.WAIT_CYCLES(5)) u_w5 (
        .clock(clock), .reset_(reset_),
        .req0(req0[2]), .req1(req1[2]), .addr0(addr0[2]), .addr1(addr1[2]),
        .we0(we0[2]), .we1(we1[2]), .wdata0(wdata0[2]), .wdata1(wdata1[2]),
        .ack0(ack0[2]), .ack1(ack1[2]), .err0(err0[2]), .err1(err1[2]),
        .rdata(rdata[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
        .mem_rd_(mem_rd_[2]), .mem_we_(mem_we_[2]), .mem_rdata(mem_rdata[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-run observations gathered by run().
    int          a0_idx, a1_idx, e0_idx, e1_idx;
    int          n_ack0, n_ack1, rd_low, we_low;
    bit          overlap, timed_out, ack_after;
    logic [23:0] addr_seen;
    logic [7:0]  wd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise the requested ports on instance k and watch the bus until every
    // raised port has been acked (40-cycle bound). Cycle index 1 is the
    // sample just after the edge that first sees the request.
    task automatic run(input int k, input bit r0, input bit r1);
        bit p0, p1, seen;
        int cyc;
        a0_idx = 0; a1_idx = 0; e0_idx = 0; e1_idx = 0;
        n_ack0 = 0; n_ack1 = 0; rd_low = 0; we_low = 0;
        overlap = 0; ack_after = 0; seen = 0;
        addr_seen = '0; wd_seen = '0;
        p0 = r0; p1 = r1;
        req0[k] = r0; req1[k] = r1;
        cyc = 0;
        while ((p0 || p1) && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            if (!seen && (!mem_rd_[k] || !mem_we_[k])) begin
                seen = 1;
                addr_seen = mem_addr[k];
                wd_seen = mem_wdata[k];
            end
            if (!mem_rd_[k]) rd_low++;
            if (!mem_we_[k]) we_low++;
            if (ack0[k] && ack1[k]) overlap = 1;
            if (err0[k]) e0_idx = cyc;
            if (err1[k]) e1_idx = cyc;
            if (ack0[k]) begin
                n_ack0++;
                if (a0_idx == 0) a0_idx = cyc;
                req0[k] = 1'b0; p0 = 0;
            end
            if (ack1[k]) begin
                n_ack1++;
                if (a1_idx == 0) a1_idx = cyc;
                req1[k] = 1'b0; p1 = 0;
            end
        end
        timed_out = p0 || p1;
        req0[k] = 1'b0; req1[k] = 1'b0;
        @(posedge clock); #1;
        ack_after = ack0[k] || ack1[k] || err0[k] || err1[k];
    endtask

    initial begin
        reset_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req0[i] = 0; req1[i] = 0; addr0[i] = '0; addr1[i] = '0;
            we0[i] = 0; we1[i] = 0; wdata0[i] = '0; wdata1[i] = '0;
            mem_rdata[i] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        // Reset state
        chk("rst_ack0", ack0[0], 1'b0);
        chk("rst_ack1", ack1[0], 1'b0);
        chk("rst_err0", err0[0], 1'b0);
        chk("rst_err1", err1[0], 1'b0);
        chk("rst_rd_", mem_rd_[0], 1'b1);
        chk("rst_we_", mem_we_[0], 1'b1);
        chk("rst_addr", mem_addr[0], 24'h0);
        chk("rst_wdata", mem_wdata[0], 8'h0);
        chk("rst_rdata", rdata[0], 8'h0);
        reset_ = 1'b1;

        // 1: port 0 read
        addr0[0] = 24'h000010; we0[0] = 0; mem_rdata[0] = 8'hA5;
        run(0, 1, 0);
        chk("t1_timeout", timed_out, 1'b0);
        chk("t1_rd_width", rd_low, 2);
        chk("t1_we_width", we_low, 0);
        chk("t1_ack_lat", a0_idx, 3);
        chk("t1_addr", addr_seen, 24'h000010);
        chk("t1_rdata", rdata[0], 8'hA5);
        chk("t1_err", e0_idx, 0);
        chk("t1_pulse", ack_after, 1'b0);

        // 2: port 1 write
        addr1[0] = 24'h000020; we1[0] = 1; wdata1[0] = 8'h3C; mem_rdata[0] = 8'h77;
        run(0, 0, 1);
        chk("t2_timeout", timed_out, 1'b0);
        chk("t2_we_width", we_low, 2);
        chk("t2_rd_width", rd_low, 0);
        chk("t2_addr", addr_seen, 24'h000020);
        chk("t2_wdata", wd_seen, 8'h3C);
        chk("t2_ack_lat", a1_idx, 3);
        chk("t2_ack0", n_ack0, 0);
        chk("t2_err1", e1_idx, 0);
        chk("t2_rdata_held", rdata[0], 8'hA5);

        // 3: simultaneous requests, round robin
        we0[0] = 0; we1[0] = 0; addr0[0] = 24'h000100; addr1[0] = 24'h000200;
        run(0, 1, 1);
        chk("t3a_timeout", timed_out, 1'b0);
        chk("t3a_ack0_lat", a0_idx, 3);
        chk("t3a_ack1_lat", a1_idx, 7);
        chk("t3a_overlap", overlap, 1'b0);
        run(0, 1, 0);
        chk("t3b_ack0_lat", a0_idx, 3);
        run(0, 1, 1);
        chk("t3c_timeout", timed_out, 1'b0);
        chk("t3c_ack1_lat", a1_idx, 3);
        chk("t3c_ack0_lat", a0_idx, 7);
        chk("t3c_overlap", overlap, 1'b0);

        // 4: EPROM boundary writes
        addr0[0] = 24'hFF0000; we0[0] = 1; wdata0[0] = 8'h11;
        run(0, 1, 0);
        chk("t4a_we_width", we_low, 0);
        chk("t4a_ack_lat", a0_idx, 3);
        chk("t4a_err_with_ack", e0_idx, 3);
        chk("t4a_pulse", ack_after, 1'b0);
        addr0[0] = 24'hFEFFFF; wdata0[0] = 8'h22;
        run(0, 1, 0);
        chk("t4b_we_width", we_low, 2);
        chk("t4b_wdata", wd_seen, 8'h22);
        chk("t4b_err", e0_idx, 0);

        // All-ones address read
        addr0[0] = 24'hFFFFFF; we0[0] = 0; mem_rdata[0] = 8'h5A;
        run(0, 1, 0);
        chk("top_rd_width", rd_low, 2);
        chk("top_addr", addr_seen, 24'hFFFFFF);
        chk("top_rdata", rdata[0], 8'h5A);
        chk("top_err", e0_idx, 0);

        // 6: other wait-state counts
        addr0[1] = 24'h000040; we0[1] = 0; mem_rdata[1] = 8'hC3;
        run(1, 1, 0);
        chk("w1_rd_width", rd_low, 1);
        chk("w1_ack_lat", a0_idx, 2);
        chk("w1_rdata", rdata[1], 8'hC3);
        addr0[2] = 24'h000050; we0[2] = 0; mem_rdata[2] = 8'h96;
        run(2, 1, 0);
        chk("w5_timeout", timed_out, 1'b0);
        chk("w5_rd_width", rd_low, 5);
        chk("w5_ack_lat", a0_idx, 6);
        chk("w5_rdata", rdata[2], 8'h96);

        // 5: reset in the middle of an access
        addr0[0] = 24'h000030; we0[0] = 0; mem_rdata[0] = 8'hEE;
        req0[0] = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("t5_mid_rd", mem_rd_[0], 1'b0);
        reset_ = 1'b0; req0[0] = 1'b0;
        @(posedge clock); #1;
        chk("t5_rd_", mem_rd_[0], 1'b1);
        chk("t5_we_", mem_we_[0], 1'b1);
        chk("t5_ack0", ack0[0], 1'b0);
        chk("t5_addr", mem_addr[0], 24'h0);
        chk("t5_rdata", rdata[0], 8'h0);
        reset_ = 1'b1;
        n_ack0 = 0;
        rd_low = 0;
        repeat (6) begin
            @(posedge clock); #1;
            if (ack0[0]) n_ack0++;
            if (!mem_rd_[0]) rd_low++;
        end
        chk("t5_no_ack", n_ack0, 0);
        chk("t5_no_strobe", rd_low, 0);
        chk("t5_rdata_after", rdata[0], 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
